ecc_scrub_monitor: RTL
======================

# ecc_scrub_monitor

Downstream consumer of the SECDED read-path decoder. Per validated read, counts single-bit (corrected) and double-bit (uncorrectable) errors in saturating counters and latches address and syndrome of the first error. On each correctable error, it issues a scrub write-back of the corrected information word to the memory write port through a req/gnt handshake; the write port re-encodes the word. Sits between the decoder outputs and the memory-side arbiter and CSR block.

## Interface
Parameters:
- K, 32, information word width; equals decoder K.
- SW, 7, syndrome width; equals decoder m+1, which is 7 for K=32.
- AW, 16, memory word address width.
- CW, 8, error counter width.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- rvalid_i  in  1  decoder outputs below are valid this cycle.
- raddr_i  in  AW  address of the word being decoded.
- q_i  in  K  corrected information word from the decoder.
- syndrome_i  in  SW  decoder syndrome vector.
- sb_err_i  in  1  single-bit error; qualified by rvalid_i.
- db_err_i  in  1  double-bit error; qualified by rvalid_i.
- scrub_en_i  in  1  enables scrub write-back.
- clear_i  in  1  clears counters, capture and sticky flags.
- wb_req_o  out  1  scrub write request.
- wb_gnt_i  in  1  write port accepts the request this cycle.
- wb_addr_o  out  AW  scrub address.
- wb_data_o  out  K  scrub data.
- busy_o  out  1  a scrub is pending.
- sb_cnt_o  out  CW  saturating single-bit error count.
- db_cnt_o  out  CW  saturating double-bit error count.
- err_valid_o  out  1  capture registers hold a first error.
- err_addr_o  out  AW  address of the first error.
- err_synd_o  out  SW  syndrome of the first error.
- err_db_o  out  1  the first error was double-bit.
- db_irq_o  out  1  one-cycle pulse per double-bit error.
- scrub_drop_o  out  1  sticky flag: a scrub was dropped because one was already pending.

## Operation
- An event is rvalid_i & (sb_err_i | db_err_i). If sb_err_i and db_err_i are both high, the event is treated as double-bit only.
- Counters:
  - A single-bit event increments sb_cnt_o; a double-bit event increments db_cnt_o.
  - Both counters saturate at 2^CW-1 and never wrap.
  - clear_i in the same cycle as an event gives a result of 1 for the affected counter, because the event follows the clear.
- Capture:
  - The first event after reset or clear loads err_addr_o, err_synd_o and err_db_o, and sets err_valid_o.
  - Later events leave the capture registers unchanged until clear_i.
  - clear_i coincident with an event re-captures that event.
- db_irq_o pulses for every double-bit event, independent of capture state.
- Scrub FSM has two states, IDLE and REQ:
  - IDLE to REQ: on a single-bit event with scrub_en_i=1. raddr_i and q_i load into wb_addr_o and wb_data_o, and wb_req_o goes to 1.
  - REQ to IDLE: on wb_gnt_i=1. wb_req_o returns to 0 the next cycle.
  - In REQ, wb_addr_o and wb_data_o are held stable. scrub_en_i falling does not abort a pending request.
  - A single-bit event while in REQ with scrub_en_i=1 is not queued; it sets scrub_drop_o. The counter still increments.
  - A single-bit event in the same cycle as the wb_gnt_i that ends REQ is also dropped and sets scrub_drop_o.
  - Double-bit events never trigger a scrub, because their data is not trustworthy.
  - clear_i does not affect the FSM.
- busy_o = (state == REQ).
- sb_err_i with a syndrome that points at a parity bit still triggers a scrub: the stored codeword is wrong even though q_i is correct.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Reset values: every output is 0; FSM state is IDLE.
- Reset asserted mid-request drops wb_req_o immediately. The pending scrub is lost.
- Latencies, with the event in cycle t:
  - Counters, capture registers and db_irq_o update at t+1.
  - wb_req_o is high from t+1.
- Handshake: the transfer completes in any cycle where wb_req_o & wb_gnt_i. The next request can assert no earlier than one cycle after wb_req_o deasserts.
- Throughput: at most one scrub every two cycles. Events are accepted every cycle.

## Structure
- Package ecc_pkg holds:
  - typedef enum scrub_state_e {IDLE, REQ};
  - a helper for the syndrome width, calc_syndrome_w(K) = m+1, so SW is derived consistently with the decoder.
- Sub-module ecc_sat_counter (parameter W; ports clk_i, rst_ni, clr_i, inc_i, cnt_o): clear-then-increment, saturating. Instantiated twice.

## Test plan
- Reset, then a single-bit event at raddr_i=0x0010, q_i=0xDEADBEEF, syndrome_i=0x0B with wb_gnt_i held 0 for 3 cycles and then 1 -> sb_cnt_o=1; err_addr_o=0x0010, err_synd_o=0x0B; wb_req_o high for 4 cycles with wb_data_o=0xDEADBEEF; busy_o then falls.
- A double-bit event -> db_cnt_o=1, db_irq_o pulses for exactly 1 cycle, wb_req_o stays 0, err_db_o=1 if it is the first event.
- 300 consecutive single-bit events with CW=8 and scrub_en_i=0 -> sb_cnt_o saturates at 255; wb_req_o never asserts.
- A second single-bit event while in REQ, and another coincident with wb_gnt_i -> scrub_drop_o=1; sb_cnt_o counts both; the original wb_addr_o and wb_data_o are unchanged.
- clear_i coincident with a single-bit event at address 0x0020 after prior errors -> sb_cnt_o=1, err_addr_o=0x0020, scrub_drop_o=0.
- rst_ni asserted while wb_req_o=1 -> wb_req_o, busy_o and all counters go to 0 asynchronously; the first event after release is captured normally.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types and helpers for the ECC scrub/monitor datapath.
package ecc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } scrub_state_e;

   // SECDED syndrome width for a K-bit information word: the smallest m with
   // 2^m >= K+m+1 Hamming check bits, plus one overall parity bit.
   function automatic int calc_syndrome_w(input int k);
      int m;
      m = 0;
      for (int i = 1; i < 31; i++) begin
         if ((m == 0) && ((1 << i) >= (k + i + 1))) begin
            m = i;
         end
      end
      return m + 1;
   endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating event counter. A clear and an increment in the same cycle yield 1,
// because the increment is applied after the clear.
module ecc_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   // Clear-then-increment, holding at all-ones instead of wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= inc_i ? W'(1) : '0;
      end else if (inc_i && (cnt_o != {W{1'b1}})) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/ecc_scrub_monitor.sv
// Error monitor behind the SECDED read decoder: counts corrected and
// uncorrectable errors, captures the first one, and writes corrected words back.
module ecc_scrub_monitor
   import ecc_pkg::*;
#(
   parameter int K  = 32,
   parameter int SW = calc_syndrome_w(K),
   parameter int AW = 16,
   parameter int CW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          rvalid_i,
   input  logic [AW-1:0] raddr_i,
   input  logic [K-1:0]  q_i,
   input  logic [SW-1:0] syndrome_i,
   input  logic          sb_err_i,
   input  logic          db_err_i,
   input  logic          scrub_en_i,
   input  logic          clear_i,
   output logic          wb_req_o,
   input  logic          wb_gnt_i,
   output logic [AW-1:0] wb_addr_o,
   output logic [K-1:0]  wb_data_o,
   output logic          busy_o,
   output logic [CW-1:0] sb_cnt_o,
   output logic [CW-1:0] db_cnt_o,
   output logic          err_valid_o,
   output logic [AW-1:0] err_addr_o,
   output logic [SW-1:0] err_synd_o,
   output logic          err_db_o,
   output logic          db_irq_o,
   output logic          scrub_drop_o
);

   // A double-bit flag dominates: data flagged both ways is never trusted.
   logic db_ev_p0;
   logic sb_ev_p0;
   logic any_ev_p0;

   assign db_ev_p0  = rvalid_i & db_err_i;
   assign sb_ev_p0  = rvalid_i & sb_err_i & ~db_err_i;
   assign any_ev_p0 = db_ev_p0 | sb_ev_p0;

   scrub_state_e state_q, state_d;
   logic         load_p0;
   logic         drop_p0;

   ecc_sat_counter #(.W(CW)) u_sb_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clear_i),
      .inc_i  (sb_ev_p0),
      .cnt_o  (sb_cnt_o)
   );

   ecc_sat_counter #(.W(CW)) u_db_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clear_i),
      .inc_i  (db_ev_p0),
      .cnt_o  (db_cnt_o)
   );

   // First-error capture; a coincident clear re-arms and captures this event.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_valid_o <= 1'b0;
         err_addr_o  <= '0;
         err_synd_o  <= '0;
         err_db_o    <= 1'b0;
      end else if (any_ev_p0 && (clear_i || !err_valid_o)) begin
         err_valid_o <= 1'b1;
         err_addr_o  <= raddr_i;
         err_synd_o  <= syndrome_i;
         err_db_o    <= db_ev_p0;
      end else if (clear_i) begin
         err_valid_o <= 1'b0;
         err_addr_o  <= '0;
         err_synd_o  <= '0;
         err_db_o    <= 1'b0;
      end
   end

   // One-cycle interrupt pulse per uncorrectable read.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         db_irq_o <= 1'b0;
      end else begin
         db_irq_o <= db_ev_p0;
      end
   end

   // Sticky drop flag; a drop in the clearing cycle still registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scrub_drop_o <= 1'b0;
      end else begin
         scrub_drop_o <= (scrub_drop_o & ~clear_i) | drop_p0;
      end
   end

   // Scrub FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, request load and drop detection. Scrubs are not queued, so a
   // correctable read arriving while a request is outstanding (including its
   // grant cycle) is only counted.
   always_comb begin
      state_d = state_q;
      load_p0 = 1'b0;
      drop_p0 = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sb_ev_p0 && scrub_en_i) begin
               state_d = REQ;
               load_p0 = 1'b1;
            end
         end
         REQ: begin
            if (sb_ev_p0 && scrub_en_i) begin
               drop_p0 = 1'b1;
            end
            if (wb_gnt_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Write-back address/data, frozen for the whole request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_addr_o <= '0;
         wb_data_o <= '0;
      end else if (load_p0) begin
         wb_addr_o <= raddr_i;
         wb_data_o <= q_i;
      end
   end

   assign wb_req_o = (state_q == REQ);
   assign busy_o   = (state_q == REQ);

endmodule
